// File: rtl/seq_divider.sv
// Multi-cycle RV32M divide/remainder unit built around one shared 32-bit ripple-carry adder.
// Optional macro SEQ_DIV_EARLY_OUT_EN: finish divide-by-zero and signed overflow without iterating.
module seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StDiv,
    StNegQ,
    StNegR,
    StDone
  } state_e;

  state_e            state_q;
  logic [5:0]        cnt_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   q_q;
  logic [XLEN-1:0]   r_q;
  logic              sa_q;
  logic              sb_q;
  logic [1:0]        op_q;
  logic              dz_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic [XLEN-1:0]   add_x;
  logic [XLEN-1:0]   add_y;
  logic              add_cin;
  logic [XLEN-1:0]   add_sum;
  logic              add_cout;
  logic              carry;

  logic [XLEN:0]     p;
  logic              sub_ok;
  logic              is_signed;
  logic              dz_in;
  logic              ovf_in;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   final_res;

  // Operand steering for the single shared adder.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state_q)
      StNegA: begin
        add_x   = ~a_q;
        add_cin = 1'b1;
      end
      StNegB: begin
        add_x   = ~b_q;
        add_cin = 1'b1;
      end
      StDiv: begin
        add_x   = p[XLEN-1:0];
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      StNegQ: begin
        add_x   = ~q_q;
        add_cin = 1'b1;
      end
      StNegR: begin
        add_x   = ~r_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    add_sum = '0;
    carry   = add_cin;
    for (int i = 0; i < XLEN; i++) begin
      add_sum[i] = add_x[i] ^ add_y[i] ^ carry;
      carry      = (add_x[i] & add_y[i]) | (carry & (add_x[i] ^ add_y[i]));
    end
    add_cout = carry;
  end

  // P[32] set means the shifted remainder already exceeds any 32-bit divisor.
  assign p      = {r_q, q_q[XLEN-1]};
  assign sub_ok = p[XLEN] | add_cout;

  assign is_signed = ~op[0];
  assign dz_in     = (divisor == '0);
  assign ovf_in    = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  // a_q keeps the original dividend, which is the divide-by-zero remainder.
  always_comb begin
    if (dz_q) begin
      special_res = op_q[1] ? a_q : '1;
    end else begin
      special_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
    if (dz_q || ovf_q) begin
      final_res = special_res;
    end else if (op_q[1]) begin
      final_res = sa_q ? add_sum : r_q;
    end else begin
      final_res = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      op_q     <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush && (state_q != StIdle)) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !flush) begin
            state_q <= StNegA;
            a_q     <= dividend;
            b_q     <= divisor;
            op_q    <= op;
            sa_q    <= is_signed & dividend[XLEN-1];
            sb_q    <= is_signed & divisor[XLEN-1];
            dz_q    <= dz_in;
            ovf_q   <= ovf_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StNegA: begin
          q_q <= sa_q ? add_sum : a_q;
          r_q <= '0;
`ifdef SEQ_DIV_EARLY_OUT_EN
          if (dz_q || ovf_q) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= special_res;
          end else begin
            state_q <= StNegB;
          end
`else
          state_q <= StNegB;
`endif
        end
        StNegB: begin
          if (sb_q) begin
            b_q <= add_sum;
          end
          state_q <= StDiv;
        end
        StDiv: begin
          r_q   <= sub_ok ? add_sum : p[XLEN-1:0];
          q_q   <= {q_q[XLEN-2:0], sub_ok};
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= StNegQ;
          end
        end
        StNegQ: begin
          if (sa_q ^ sb_q) begin
            q_q <= add_sum;
          end
          state_q <= StNegR;
        end
        StNegR: begin
          if (sa_q) begin
            r_q <= add_sum;
          end
          result_q <= final_res;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider, with a short random pass against a reference model.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp;
  int n_err;

  seq_divider #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_DIV_EARLY_OUT_EN
    if (b == 32'h0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 36;
  endfunction

  task automatic do_accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int lat;
    do_accept(o, a, b);
    chk({tag, " busy@accept"}, {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat(o, a, b)));
    chk({tag, " result"}, result, exp);
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, {31'b0, done}, 32'd0);
    chk({tag, " busy fall"}, {31'b0, busy}, 32'd0);
    chk({tag, " result hold"}, result, exp);
  endtask

  initial begin
    int lat;
    int extra_done;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'b00;
    dividend = 32'h0;
    divisor  = 32'h0;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14);
    run("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2);
    run("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run("div -7/-2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3);
    run("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5);
    run("div -5/0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run("rem -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Flush during the 10th DIV cycle; prior result is 0x80000000.
    do_accept(2'b01, 32'd1000, 32'd10);
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush result", result, 32'h8000_0000);
    extra_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra_done++;
    end
    chk("flush no done", 32'(extra_done), 32'd0);
    run("after flush", 2'b01, 32'd1000, 32'd10, 32'd100);

    // Flush in IDLE must block a simultaneous start.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("idle flush blocks start", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-DIV.
    do_accept(2'b01, 32'd100, 32'd7);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra_done++;
    end
    chk("midreset no done", 32'(extra_done), 32'd0);

    // A start while busy must not disturb the in-flight operation.
    do_accept(2'b01, 32'd100, 32'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    op       = 2'b00;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd3;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done(lat);
    chk("busy start latency", 32'(lat + 8), 32'd36);
    chk("busy start result", result, 32'd14);
    @(posedge clk);
    #1;
    chk("busy start single done", {31'b0, done}, 32'd0);

    for (int i = 0; i < 100; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 3) rb = 32'd0;
      if (i % 10 == 7) rb = 32'($urandom_range(1, 255));
      if (i % 25 == 11) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      run("rand", ro, ra, rb, model(ro, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
